// File: rtl/md_sequencer.sv
// Multiply/divide sequencer owning the HI/LO pair: multi-cycle MULT/MULTU, 32-step restoring
// DIV/DIVU with a sign-fix cycle, single-cycle MTHI/MTLO, and pipeline-flush abort.
module md_sequencer #(
  parameter int unsigned MUL_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        md_start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        flush,
  output logic        isbusy,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        md_done
);

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;

  localparam logic [2:0] OpMult  = 3'd0;
  localparam logic [2:0] OpMultu = 3'd1;
  localparam logic [2:0] OpDiv   = 3'd2;
  localparam logic [2:0] OpDivu  = 3'd3;
  localparam logic [2:0] OpMthi  = 3'd4;
  localparam logic [2:0] OpMtlo  = 3'd5;

  localparam logic [4:0] MulCntInit = 5'(MUL_CYCLES - 1);
  localparam logic [4:0] DivCntInit = 5'd31;

  state_e      state_q;
  logic [4:0]  cnt_q;
  logic [31:0] hi_q, lo_q;
  logic [31:0] op_a_q, op_b_q;
  logic [31:0] quo_q, rem_q;
  logic        mul_signed_q;
  logic        neg_quo_q, neg_rem_q;
  logic        done_q;

  // Multiply: 33-bit operands carry the sign (MULT) or a zero (MULTU) so one signed multiplier
  // serves both flavours.
  logic [32:0] mul_a, mul_b;
  logic [65:0] prod_full;

  always_comb begin
    mul_a     = {mul_signed_q & op_a_q[31], op_a_q};
    mul_b     = {mul_signed_q & op_b_q[31], op_b_q};
    prod_full = $signed(mul_a) * $signed(mul_b);
  end

  // Divide step: quo_q starts as the dividend magnitude and its MSB is shifted into the
  // partial remainder while quotient bits are shifted in at the LSB.
  logic [32:0] div_shift;
  logic [33:0] div_diff;
  logic        div_ge;

  always_comb begin
    div_shift = {rem_q, quo_q[31]};
    div_diff  = {1'b0, div_shift} - {2'b00, op_b_q};
    div_ge    = ~div_diff[33];
  end

  // Operand magnitudes and result sign fix-up.
  logic        is_sdiv;
  logic [31:0] a_abs, b_abs;
  logic [31:0] fix_quo, fix_rem;

  always_comb begin
    is_sdiv = (md_op == OpDiv);
    a_abs   = (is_sdiv && rs_data[31]) ? (~rs_data + 32'd1) : rs_data;
    b_abs   = (is_sdiv && rt_data[31]) ? (~rt_data + 32'd1) : rt_data;
    fix_quo = neg_quo_q ? (~quo_q + 32'd1) : quo_q;
    fix_rem = neg_rem_q ? (~rem_q + 32'd1) : rem_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      cnt_q        <= 5'd0;
      hi_q         <= 32'd0;
      lo_q         <= 32'd0;
      op_a_q       <= 32'd0;
      op_b_q       <= 32'd0;
      quo_q        <= 32'd0;
      rem_q        <= 32'd0;
      mul_signed_q <= 1'b0;
      neg_quo_q    <= 1'b0;
      neg_rem_q    <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (flush) begin
        // Abort wins over both a concurrent start and a completing write.
        state_q <= StIdle;
        cnt_q   <= 5'd0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (md_start) begin
              case (md_op)
                OpMult, OpMultu: begin
                  state_q      <= StMul;
                  cnt_q        <= MulCntInit;
                  op_a_q       <= rs_data;
                  op_b_q       <= rt_data;
                  mul_signed_q <= (md_op == OpMult);
                end
                OpDiv, OpDivu: begin
                  state_q   <= StDiv;
                  cnt_q     <= DivCntInit;
                  quo_q     <= a_abs;
                  rem_q     <= 32'd0;
                  op_b_q    <= b_abs;
                  neg_quo_q <= is_sdiv & (rs_data[31] ^ rt_data[31]);
                  neg_rem_q <= is_sdiv & rs_data[31];
                end
                OpMthi: hi_q <= rs_data;
                OpMtlo: lo_q <= rs_data;
                default: ;
              endcase
            end
          end
          StMul: begin
            if (cnt_q == 5'd0) begin
              hi_q    <= prod_full[63:32];
              lo_q    <= prod_full[31:0];
              state_q <= StIdle;
              done_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q - 5'd1;
            end
          end
          StDiv: begin
            // A set div_shift[32] always implies div_ge, so the low 32 bits suffice on restore.
            rem_q <= div_ge ? div_diff[31:0] : div_shift[31:0];
            quo_q <= {quo_q[30:0], div_ge};
            if (cnt_q == 5'd0) begin
              state_q <= StFix;
            end else begin
              cnt_q <= cnt_q - 5'd1;
            end
          end
          StFix: begin
            lo_q    <= fix_quo;
            hi_q    <= fix_rem;
            state_q <= StIdle;
            done_q  <= 1'b1;
          end
        endcase
      end
    end
  end

  assign isbusy  = (state_q != StIdle);
  assign hi_out  = hi_q;
  assign lo_out  = lo_q;
  assign md_done = done_q;

endmodule

// File: tb/tb_md_sequencer.sv
// Self-checking bench for md_sequencer: directed vector table, flush/reset/busy corner
// sequences, and randomized operations against an arithmetic reference model.
module tb_md_sequencer;

  localparam int unsigned MC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        md_start = 1'b0;
  logic [2:0]  md_op = 3'd0;
  logic [31:0] rs_data = 32'd0;
  logic [31:0] rt_data = 32'd0;
  logic        flush = 1'b0;
  logic        isbusy;
  logic [31:0] hi_out, lo_out;
  logic        md_done;

  int total = 0;
  int bad = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  md_sequencer #(.MUL_CYCLES(MC)) dut (
    .clk     (clk),
    .rst     (rst),
    .md_start(md_start),
    .md_op   (md_op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .flush   (flush),
    .isbusy  (isbusy),
    .hi_out  (hi_out),
    .lo_out  (lo_out),
    .md_done (md_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference results straight from the arithmetic definitions.
  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                inout logic [31:0] hi, inout logic [31:0] lo);
    longint sa, sb, p;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
      3'd1: begin up = {32'd0, a} * {32'd0, b}; hi = up[63:32]; lo = up[31:0]; end
      3'd2: begin
        if (b == 32'd0) begin
          hi = a;
          lo = (sa < 0) ? 32'd1 : 32'hFFFFFFFF;
        end else begin
          p  = sa / sb;
          lo = p[31:0];
          p  = sa % sb;
          hi = p[31:0];
        end
      end
      3'd3: begin
        if (b == 32'd0) begin hi = a; lo = 32'hFFFFFFFF; end
        else begin lo = a / b; hi = a % b; end
      end
      3'd4: hi = a;
      3'd5: lo = a;
      default: ;
    endcase
  endfunction

  function automatic int exp_busy(input logic [2:0] op);
    if (op < 3'd2) return int'(MC);
    if (op < 3'd4) return 33;
    return 0;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'($urandom_range(0, 20));
      1: return 32'd0;
      2: return 32'h80000000;
      3: return 32'hFFFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  // Called at a negedge; returns at the first negedge with isbusy low.
  task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int busy, output logic done, output logic [31:0] hi,
                        output logic [31:0] lo);
    md_start = 1'b1;
    md_op    = op;
    rs_data  = a;
    rt_data  = b;
    @(negedge clk);
    md_start = 1'b0;
    busy = 0;
    while (isbusy && busy < 100) begin
      busy++;
      @(negedge clk);
    end
    done = md_done;
    hi   = hi_out;
    lo   = lo_out;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          busy;
  } vec_t;

  vec_t vt[8];

  initial begin
    int n;
    logic d;
    logic [31:0] h, l;
    logic [2:0] op;
    logic [31:0] a, b;

    vt[0] = '{3'd0, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, int'(MC)};
    vt[1] = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, int'(MC)};
    vt[2] = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33};
    vt[3] = '{3'd3, 32'd100,      32'd7,        32'd2,        32'd14,       33};
    vt[4] = '{3'd3, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 33};
    vt[5] = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 33};
    vt[6] = '{3'd2, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 33};
    vt[7] = '{3'd0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, int'(MC)};

    repeat (2) @(negedge clk);
    check("reset_busy", {31'd0, isbusy}, 32'd0);
    check("reset_done", {31'd0, md_done}, 32'd0);
    check("reset_hi", hi_out, 32'd0);
    check("reset_lo", lo_out, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_md(vt[i].op, vt[i].a, vt[i].b, n, d, h, l);
      check($sformatf("vec%0d_busy", i), 32'(n), 32'(vt[i].busy));
      check($sformatf("vec%0d_done", i), {31'd0, d}, 32'd1);
      check($sformatf("vec%0d_hi", i), h, vt[i].hi);
      check($sformatf("vec%0d_lo", i), l, vt[i].lo);
      m_hi = vt[i].hi;
      m_lo = vt[i].lo;
      @(negedge clk);
      check($sformatf("vec%0d_pulse", i), {31'd0, md_done}, 32'd0);
    end

    // MTHI then MTLO on consecutive cycles.
    md_start = 1'b1; md_op = 3'd4; rs_data = 32'h12345678;
    @(negedge clk);
    md_op = 3'd5; rs_data = 32'h9ABCDEF0;
    check("mthi_busy", {31'd0, isbusy}, 32'd0);
    check("mthi_hi", hi_out, 32'h12345678);
    @(negedge clk);
    md_start = 1'b0;
    check("mtlo_busy", {31'd0, isbusy}, 32'd0);
    check("mtlo_lo", lo_out, 32'h9ABCDEF0);
    check("mtlo_hi", hi_out, 32'h12345678);
    m_hi = 32'h12345678;
    m_lo = 32'h9ABCDEF0;

    // Flush on busy cycle 10 of a DIV.
    md_start = 1'b1; md_op = 3'd2; rs_data = 32'd1000; rt_data = 32'd3;
    @(negedge clk);
    md_start = 1'b0;
    repeat (9) @(negedge clk);
    check("fl10_busy_before", {31'd0, isbusy}, 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("fl10_busy", {31'd0, isbusy}, 32'd0);
    check("fl10_done", {31'd0, md_done}, 32'd0);
    check("fl10_hi", hi_out, m_hi);
    check("fl10_lo", lo_out, m_lo);
    @(negedge clk);
    check("fl10_done_late", {31'd0, md_done}, 32'd0);

    // Flush together with an MTLO start.
    md_start = 1'b1; md_op = 3'd5; rs_data = 32'hDEADBEEF; flush = 1'b1;
    @(negedge clk);
    md_start = 1'b0; flush = 1'b0;
    check("flmt_busy", {31'd0, isbusy}, 32'd0);
    check("flmt_lo", lo_out, m_lo);

    // Flush in the FIX cycle (busy cycle 33).
    md_start = 1'b1; md_op = 3'd3; rs_data = 32'd100; rt_data = 32'd7;
    @(negedge clk);
    md_start = 1'b0;
    repeat (32) @(negedge clk);
    check("flfix_busy_before", {31'd0, isbusy}, 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flfix_busy", {31'd0, isbusy}, 32'd0);
    check("flfix_done", {31'd0, md_done}, 32'd0);
    check("flfix_hi", hi_out, m_hi);
    check("flfix_lo", lo_out, m_lo);
    @(negedge clk);

    // Start while busy is ignored.
    md_start = 1'b1; md_op = 3'd3; rs_data = 32'd100; rt_data = 32'd7;
    @(negedge clk);
    md_start = 1'b0;
    n = 0;
    while (isbusy && n < 100) begin
      n++;
      if (n == 5) begin
        md_start = 1'b1; md_op = 3'd0; rs_data = 32'd9; rt_data = 32'd9;
      end else begin
        md_start = 1'b0;
      end
      @(negedge clk);
    end
    md_start = 1'b0;
    check("sdb_busy", 32'(n), 32'd33);
    check("sdb_done", {31'd0, md_done}, 32'd1);
    check("sdb_hi", hi_out, 32'd2);
    check("sdb_lo", lo_out, 32'd14);
    m_hi = 32'd2;
    m_lo = 32'd14;
    @(negedge clk);
    check("sdb_idle", {31'd0, isbusy}, 32'd0);

    // Randomized operations, back-to-back or with idle gaps.
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = pick();
      b  = pick();
      model(op, a, b, m_hi, m_lo);
      run_md(op, a, b, n, d, h, l);
      check($sformatf("rnd%0d_op%0d_busy", i, op), 32'(n), 32'(exp_busy(op)));
      check($sformatf("rnd%0d_op%0d_done", i, op), {31'd0, d}, {31'd0, (op < 3'd4)});
      check($sformatf("rnd%0d_op%0d_hi a=%h b=%h", i, op, a, b), h, m_hi);
      check($sformatf("rnd%0d_op%0d_lo a=%h b=%h", i, op, a, b), l, m_lo);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    // Reset asserted mid-MUL.
    md_start = 1'b1; md_op = 3'd0; rs_data = 32'd3; rt_data = 32'd5;
    @(negedge clk);
    md_start = 1'b0;
    check("rstmul_busy_before", {31'd0, isbusy}, 32'd1);
    #1 rst = 1'b0;
    #1;
    check("rstmul_busy", {31'd0, isbusy}, 32'd0);
    check("rstmul_hi", hi_out, 32'd0);
    check("rstmul_lo", lo_out, 32'd0);
    check("rstmul_done", {31'd0, md_done}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rstmul_after_busy", {31'd0, isbusy}, 32'd0);
    check("rstmul_after_done", {31'd0, md_done}, 32'd0);
    check("rstmul_after_lo", lo_out, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/md_sequencer.md
# md_sequencer

Multiply/divide sequencer owning the HI/LO register pair for the MIPS pipeline. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the EX stage, runs multi-cycle multiply or 32-iteration restoring divide, and drives `isbusy`. The stall unit combines `isbusy` with `RHL_visit` to freeze PF..ID while EX..WB keep draining. A pipeline flush from MEM1 (exception/ERET) aborts any in-flight operation.

## Interface
- `MUL_CYCLES`, 2: busy cycles for a multiply, legal range 1..7.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `md_start`  in  1  EX-stage request valid for one cycle.
- `md_op`  in  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; 6–7 ignored.
- `rs_data`  in  32  operand A / dividend / MTHI-MTLO source.
- `rt_data`  in  32  operand B / divisor.
- `flush`  in  1  MEM1_ex | MEM1_eret_flush; kills start and in-flight op.
- `isbusy`  out  1  high while an operation is in flight.
- `hi_out`  out  32  architectural HI.
- `lo_out`  out  32  architectural LO.
- `md_done`  out  1  one-cycle pulse on the cycle after HI/LO are written by MULT*/DIV*.

## Operation
- States: IDLE, MUL, DIV, FIX. `isbusy` = (state != IDLE), decoded from registered state only.
- IDLE, `md_start`, `flush`=0:
  - MULT/MULTU → MUL. Latch operands, cnt=MUL_CYCLES-1.
  - DIV/DIVU → DIV. Latch |A|, |B| (DIVU: raw values) and the sign bits, cnt=31.
  - MTHI/MTLO → write HI/LO from `rs_data` at this edge; stay IDLE.
  - md_op 6–7 → no effect.
- `md_start` while busy: ignored. The stall unit never issues it.
- MUL: 64-bit product, signed (MULT) or unsigned (MULTU). cnt decrements each cycle. At cnt==0, {HI,LO}←product, go IDLE.
- DIV: restoring divide on magnitudes, one quotient bit per cycle, MSB first.
  - Partial remainder is 33 bits: shift left, subtract divisor, keep the result if it is non-negative.
  - At cnt==0 go FIX.
- FIX:
  - DIV: negate quotient if the operand signs differ; give the remainder the dividend's sign.
  - Write LO←quotient, HI←remainder, go IDLE.
- Divide by zero is deterministic, no trap. Unsigned result: Q=0xFFFFFFFF, R=dividend. DIV then applies the FIX sign rules to that.
- DIV of 0x80000000 by 0xFFFFFFFF: LO=0x80000000, HI=0.
- `flush` at an edge: state→IDLE, HI/LO unchanged, any concurrent `md_start` (including MTHI/MTLO) discarded. Flush has priority over completion in the same cycle.
- Reset: state=IDLE, HI=LO=0, cnt=0, `isbusy`=0, `md_done`=0.

## Timing
- Start accepted at edge E0. `isbusy` high from the cycle after E0.
- Busy lengths:
  - MUL: busy MUL_CYCLES cycles.
  - DIV: busy 33 cycles (32 DIV + 1 FIX).
- HI/LO change at the edge that ends the last busy cycle. `isbusy` is low and `md_done` high in the following cycle.
- MTHI/MTLO: HI/LO visible the cycle after E0. `isbusy` never asserts.
- Back-to-back: a new start is accepted in the first cycle `isbusy`=0. `md_done` may coincide with that accept.
- `rst` assertion mid-operation: immediate return to reset values, no partial HI/LO write.

## Test plan
- MULT rs=0xFFFFFFFE (−2), rt=3, MUL_CYCLES=2 → `isbusy` high exactly 2 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA, `md_done` 1 cycle.
- MULTU 0xFFFFFFFF×0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- DIV −7/2 → busy 33 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100/7 → LO=14, HI=2.
- DIVU 5/0 → LO=0xFFFFFFFF, HI=5. DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- Flush:
  - Flush on cycle 10 of a DIV → `isbusy` low next cycle, HI/LO hold prior values, no `md_done`.
  - Flush with `md_start`+MTLO in the same cycle → LO unchanged.
  - Flush in the FIX cycle → no write.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 on consecutive cycles → values visible next cycles, `isbusy` stays 0.
- Reset asserted mid-MUL → HI=LO=0, `isbusy`=0 immediately.
- Start during busy → ignored, result of the first operation unaffected.
